// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-ported, synchronous-read SRAM between
// the instruction-fetch and data ports of the core. Every accepted access
// returns its response exactly one cycle later, and a new access can issue
// in that same cycle.
//
// Optional feature: define ARB_RR_EN for round-robin arbitration on
// contention. Without it, the data port always wins.
//
// resp   | meaning
// -------+-----------------------------------------------------
// IDLE   | no SRAM response arrives this cycle
// I_PEND | SRAM read data arriving this cycle belongs to inst
// D_PEND | SRAM response arriving this cycle belongs to data
module sram_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_PEND = 2'd1,
        D_PEND = 2'd2
    } resp_t;

    resp_t             r_resp;
    resp_t             w_resp_nxt;
    logic              w_gnt_i;
    logic              w_gnt_d;
    logic              r_wr_pend;
    logic [DATA_W-1:0] r_inst_rdata;
    logic [DATA_W-1:0] r_data_rdata;

`ifdef ARB_RR_EN
    localparam logic PTR_INST = 1'b0;
    localparam logic PTR_DATA = 1'b1;

    logic r_rr_ptr;

    // Grant: the pointer's side wins a tie, otherwise whoever asks
    always_comb begin
        w_gnt_d = data_req && (!inst_req || (r_rr_ptr == PTR_DATA));
        w_gnt_i = inst_req && !w_gnt_d;
    end

    // Pointer moves to the loser after a contended grant only
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= PTR_DATA;
        end else if (inst_req && data_req) begin
            r_rr_ptr <= w_gnt_d ? PTR_INST : PTR_DATA;
        end
    end
`else
    // Grant: data has fixed priority over inst
    always_comb begin
        w_gnt_d = data_req;
        w_gnt_i = inst_req && !data_req;
    end
`endif

    // State register: owner of the response arriving next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp <= IDLE;
        end else begin
            r_resp <= w_resp_nxt;
        end
    end

    // Next state follows the current grant, independent of r_resp
    always_comb begin
        w_resp_nxt = IDLE;
        if (w_gnt_d) begin
            w_resp_nxt = D_PEND;
        end else if (w_gnt_i) begin
            w_resp_nxt = I_PEND;
        end
    end

    // Remember whether the outstanding data access is a store
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_pend <= 1'b0;
        end else if (w_gnt_d) begin
            r_wr_pend <= data_wr;
        end
    end

    // Hold registers keep the last read data for each side
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            if (r_resp == I_PEND) begin
                r_inst_rdata <= mem_rdata;
            end
            if ((r_resp == D_PEND) && !r_wr_pend) begin
                r_data_rdata <= mem_rdata;
            end
        end
    end

    // Outputs: SRAM drive from the winner, responses bypass mem_rdata
    always_comb begin
        inst_addr_ok = w_gnt_i;
        data_addr_ok = w_gnt_d;
        mem_en       = w_gnt_i || w_gnt_d;
        mem_wen      = '0;
        mem_addr     = '0;
        mem_wdata    = '0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = r_inst_rdata;
        data_rdata   = r_data_rdata;
        if (w_gnt_d) begin
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
            mem_wen   = data_wr ? data_wen : {BE_W{1'b0}};
        end else if (w_gnt_i) begin
            mem_addr  = inst_addr;
        end
        case (r_resp)
            I_PEND: begin
                inst_data_ok = 1'b1;
                inst_rdata   = mem_rdata;
            end
            D_PEND: begin
                data_data_ok = 1'b1;
                if (!r_wr_pend) begin
                    data_rdata = mem_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM model, reference scoreboard and directed
// scenarios followed by protocol-compliant random traffic.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // SRAM: below 0x100 a real word array, above it returns address+1
    logic [31:0] sram_mem [0:63];
    logic [31:0] ref_mem  [0:63];

    always @(posedge clk) begin
        logic [31:0] w;
        if (mem_en) begin
            if (mem_addr >= 32'h100) begin
                mem_rdata <= mem_addr + 32'd1;
            end else if (mem_wen != 4'b0) begin
                w = sram_mem[mem_addr[7:2]];
                for (int b = 0; b < 4; b++)
                    if (mem_wen[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                sram_mem[mem_addr[7:2]] <= w;
                mem_rdata <= 32'hBAD0BAD0;
            end else begin
                mem_rdata <= sram_mem[mem_addr[7:2]];
            end
        end
    end

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (a >= 32'h100) return a + 32'd1;
        return ref_mem[a[7:2]];
    endfunction

    // Scoreboard: expected responses queued at grant, popped a cycle later
    logic [31:0] q_i [$];
    logic [32:0] q_d [$];   // {is_store, load data}
    logic [31:0] exp_i_hold = '0;
    logic [31:0] exp_d_hold = '0;
    logic        ref_ptr_d  = 1'b1;

    always @(negedge clk) begin
        logic        gi, gd;
        logic [31:0] e;
        logic [32:0] ed;
        logic [31:0] w;
        if (q_i.size() > 0) begin
            e = q_i.pop_front();
            exp_i_hold = e;
            chk("inst_data_ok", {31'b0, inst_data_ok}, 32'd1);
            chk("inst_rdata", inst_rdata, e);
        end else begin
            chk("inst_data_ok", {31'b0, inst_data_ok}, 32'd0);
            chk("inst_rdata_hold", inst_rdata, exp_i_hold);
        end
        if (q_d.size() > 0) begin
            ed = q_d.pop_front();
            if (!ed[32]) exp_d_hold = ed[31:0];
            chk("data_data_ok", {31'b0, data_data_ok}, 32'd1);
            chk("data_rdata", data_rdata, exp_d_hold);
        end else begin
            chk("data_data_ok", {31'b0, data_data_ok}, 32'd0);
            chk("data_rdata_hold", data_rdata, exp_d_hold);
        end
`ifdef ARB_RR_EN
        gd = data_req && (!inst_req || ref_ptr_d);
`else
        gd = data_req;
`endif
        gi = inst_req && !gd;
        chk("inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, gi});
        chk("data_addr_ok", {31'b0, data_addr_ok}, {31'b0, gd});
        chk("mem_en", {31'b0, mem_en}, {31'b0, gi | gd});
        chk("mem_wen", {28'b0, mem_wen}, (gd && data_wr) ? {28'b0, data_wen} : 32'd0);
        chk("mem_addr", mem_addr, gd ? data_addr : (gi ? inst_addr : 32'd0));
        chk("mem_wdata", mem_wdata, gd ? data_wdata : 32'd0);
        if (rst) begin
            q_i.delete();
            q_d.delete();
            exp_i_hold = '0;
            exp_d_hold = '0;
            ref_ptr_d  = 1'b1;
        end else begin
            if (gi) q_i.push_back(ref_rd(inst_addr));
            if (gd) begin
                if (data_wr) begin
                    w = ref_mem[data_addr[7:2]];
                    for (int b = 0; b < 4; b++)
                        if (data_wen[b]) w[8*b +: 8] = data_wdata[8*b +: 8];
                    ref_mem[data_addr[7:2]] = w;
                    q_d.push_back({1'b1, 32'd0});
                end else begin
                    q_d.push_back({1'b0, ref_rd(data_addr)});
                end
            end
            if (inst_req && data_req) ref_ptr_d = !gd;
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int gd_cnt, gi_cnt, gi_second;
        logic i_ok, d_ok;
        for (int k = 0; k < 64; k++) begin
            sram_mem[k] = '0;
            ref_mem[k]  = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_mem_en", {31'b0, mem_en}, 32'd0);
            chk("idle_inst_rdata", inst_rdata, 32'd0);
            chk("idle_data_rdata", data_rdata, 32'd0);
            next_cyc();
        end

        // Inst-only stream
        inst_req = 1'b1;
        inst_addr = 32'h1FC0_0000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("ionly_addr_ok", {31'b0, inst_addr_ok}, 32'd1);
            if (k >= 1) begin
                chk("ionly_data_ok", {31'b0, inst_data_ok}, 32'd1);
                chk("ionly_rdata", inst_rdata, 32'h1FC0_0001);
            end
            next_cyc();
        end
        inst_req = 1'b0;
        @(negedge clk);
        chk("ionly_last_ok", {31'b0, inst_data_ok}, 32'd1);
        next_cyc();

        // Store then load
        data_req = 1'b1; data_wr = 1'b1; data_wen = 4'b0011;
        data_addr = 32'h10; data_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("st_mem_wen", {28'b0, mem_wen}, 32'h3);
        next_cyc();
        data_wr = 1'b0; data_wen = 4'b0; data_wdata = '0;
        @(negedge clk);
        chk("st_data_ok", {31'b0, data_data_ok}, 32'd1);
        chk("st_rdata_kept", data_rdata, 32'd0);
        next_cyc();
        data_req = 1'b0;
        @(negedge clk);
        chk("ld_data_ok", {31'b0, data_data_ok}, 32'd1);
        chk("ld_rdata", data_rdata, 32'h0000_BEEF);
        next_cyc();

        // Contention for 3 cycles, then data drops
        inst_req = 1'b1; inst_addr = 32'h1FC0_0040;
        data_req = 1'b1; data_addr = 32'h20;
        gd_cnt = 0; gi_cnt = 0; gi_second = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (data_addr_ok) gd_cnt++;
            if (inst_addr_ok) begin
                gi_cnt++;
                if (k == 1) gi_second = 1;
            end
            next_cyc();
        end
        data_req = 1'b0;
        @(negedge clk);
        chk("cont_inst_c4", {31'b0, inst_addr_ok}, 32'd1);
`ifdef ARB_RR_EN
        chk("cont_d_grants", gd_cnt, 32'd2);
        chk("cont_i_grants", gi_cnt, 32'd1);
        chk("cont_i_second", gi_second, 32'd1);
`else
        chk("cont_d_grants", gd_cnt, 32'd3);
        chk("cont_i_grants", gi_cnt, 32'd0);
`endif
        next_cyc();
        inst_req = 1'b0;
        repeat (2) next_cyc();

        // Reset while an inst response is pending
        inst_req = 1'b1; inst_addr = 32'h1FC0_0080;
        next_cyc();
        inst_req = 1'b0; rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_no_data_ok", {31'b0, inst_data_ok}, 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        next_cyc();

        // Random traffic; requests held until accepted
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            i_ok = inst_addr_ok;
            d_ok = data_addr_ok;
            next_cyc();
            if (!inst_req || i_ok) begin
                inst_req  = ($urandom_range(0, 3) != 0);
                inst_addr = 32'h1FC0_0000 + 32'($urandom_range(0, 15)) * 4;
            end
            if (!data_req || d_ok) begin
                data_req   = ($urandom_range(0, 2) != 0);
                data_wr    = $urandom_range(0, 1) == 1;
                data_wen   = data_wr ? 4'($urandom_range(1, 15)) : 4'b0;
                data_addr  = 32'($urandom_range(0, 15)) * 4;
                data_wdata = $urandom;
            end
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        repeat (3) next_cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-ported, synchronous-read SRAM between the CPU core's instruction-fetch port and its data port. It is used when the SoC provides a single memory instead of separate inst/data SRAMs. Each side sees a request/acknowledge SRAM-like interface with split address-phase (`*_addr_ok`) and data-phase (`*_data_ok`) handshakes. The core stalls on a missing `*_addr_ok` or a missing `*_data_ok`. Addresses arriving here are already physical, i.e. translated upstream.

## Interface
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; byte-enable width is `DATA_W/8`.

Ports:
- `clk` input 1: clock, all state updates on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `inst_req` input 1: fetch request; held until `inst_addr_ok`.
- `inst_addr` input ADDR_W: fetch address.
- `inst_addr_ok` output 1: fetch accepted this cycle (combinational).
- `inst_data_ok` output 1: fetch data valid this cycle.
- `inst_rdata` output DATA_W: fetch data, held until the next `inst_data_ok`.
- `data_req` input 1: load/store request; held until `data_addr_ok`.
- `data_wr` input 1: 1 = store.
- `data_wen` input DATA_W/8: store byte enables.
- `data_addr` input ADDR_W: load/store address.
- `data_wdata` input DATA_W: store data.
- `data_addr_ok` output 1: load/store accepted this cycle (combinational).
- `data_data_ok` output 1: load data valid, or store complete.
- `data_rdata` output DATA_W: load data, held until the next `data_data_ok`.
- `mem_en` output 1: SRAM enable.
- `mem_wen` output DATA_W/8: SRAM byte write enables.
- `mem_addr` output ADDR_W: SRAM address.
- `mem_wdata` output DATA_W: SRAM write data.
- `mem_rdata` input DATA_W: SRAM read data, valid the cycle after the address.

## Operation
- State register `resp`: IDLE, I_PEND, or D_PEND. It records which side owns the SRAM response arriving in the current cycle.
- Grant, combinational each cycle:
  - Only `data_req`: grant data.
  - Only `inst_req`: grant inst.
  - Both: grant data (default; see Configuration).
  - Neither: no grant.
- A grant is independent of `resp`. A new access may issue in the same cycle a previous response returns, giving full back-to-back throughput.
- On a grant, the granted side's `*_addr_ok` = 1 and `mem_en` = 1. `mem_addr` and `mem_wdata` come from the winner.
- `mem_wen` = `data_wen` only when data is granted and `data_wr` = 1; otherwise 0.
- With no grant: `mem_en` = 0, `mem_wen` = 0, `mem_addr`/`mem_wdata` = 0.
- State transition at each edge: `resp` becomes I_PEND if inst was granted, D_PEND if data was granted, IDLE otherwise.
- In I_PEND: `inst_data_ok` = 1, and `inst_rdata` captures `mem_rdata` into a hold register. The output is a bypass of `mem_rdata` in this cycle and the held value afterwards.
- In D_PEND: `data_data_ok` = 1. For a load, `data_rdata` is captured and bypassed the same way. For a store, `data_data_ok` still pulses and `data_rdata` keeps its previous value; a `wr_pend` flag records the access type.
- Data outputs are updated only by their own side's response.

## Timing
- Reset values:
  - `resp` = IDLE.
  - `inst_data_ok`, `data_data_ok` = 0.
  - Both rdata hold registers = 0.
  - Round-robin pointer (when configured in) = DATA.
  - `mem_*` outputs follow the request inputs combinationally and are 0 when no request is pending.
- Latency: `*_addr_ok` in cycle t means `*_data_ok` in cycle t+1, exactly. There are no variable delays.
- A side denied a grant sees `*_addr_ok` = 0 and must hold its request stable. Its wait length equals the number of consecutive cycles the other side is granted.
- Reset asserted while a response is pending: the pending response is discarded. No `*_data_ok` appears in the cycle after reset releases.
- `*_req` dropped without `*_addr_ok` is a protocol violation; behaviour is unspecified.
- At most one `*_data_ok` is high per cycle.

## Configuration
- `ARB_RR_EN` defined: round-robin on contention.
  - A 1-bit pointer names the preferred side; the pointer's side wins when both request.
  - After any contended grant, the pointer flips to the loser.
  - Uncontended grants leave the pointer unchanged.
- `ARB_RR_EN` not defined: fixed data priority; no pointer register.

## Test plan
- Reset, then no requests for 3 cycles: `mem_en` = 0; both `*_data_ok` = 0; `inst_rdata` = `data_rdata` = 0.
- Inst-only: `inst_req` = 1 at `0x1FC00000` for 4 cycles, SRAM model returns the address plus 1:
  - `inst_addr_ok` = 1 each cycle.
  - `inst_data_ok` = 1 from cycle t+1 onward.
  - `inst_rdata` = `0x1FC00001` in cycle t+1.
- Store then load to `0x00000010`:
  - Store with wen `4'b0011`, wdata `0xDEADBEEF`: `mem_wen` = `4'b0011` in the issue cycle; `data_data_ok` the next cycle with `data_rdata` unchanged.
  - Following load: `data_rdata` = `0x0000BEEF` when the SRAM is pre-zeroed.
- Contention, both requesting for 3 cycles, without `ARB_RR_EN`: data granted 3 times and inst 0 times; inst granted in cycle 4 after `data_req` drops.
- The same contention with `ARB_RR_EN`: grants go D, I, D; `inst_addr_ok` comes in the second cycle.
- Reset asserted in the cycle after an inst grant: no `inst_data_ok` appears in the cycle after release, and `inst_rdata` = 0.
